vector_reduction_minmax_unit: RTL

Sequential reduction engine for vredmin/vredmax/vredminu/vredmaxu. It folds a stream of 64-bit vs2 register beats, plus a scalar seed taken from vs1 element 0, into one SEW-wide minimum or maximum. It sits in the integer vector datapath beside the element-wise min/max unit and is fed beat-by-beat by the register-file read sequencer. The result goes back to the writeback stage for vd element 0.

---
 rtl/vector_reduction_minmax_unit.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/vector_reduction_minmax_unit.sv
`default_nettype none
// ============================================================================
// Module   : vector_reduction_minmax_unit
// Purpose  : Sequential vredmin/vredmax/vredminu/vredmaxu engine. Folds a
//            stream of 64-bit vs2 beats and the vs1[0] seed into one SEW-wide
//            minimum or maximum, which is returned for vd element 0.
// Options  : VECTOR_REDUCTION_MASK_EN adds the per-lane beat_mask input.
// Revision : 1.0 - initial release
// ============================================================================

package vector_reduction_minmax_pkg;

    typedef enum logic [1:0] {
        BIT_MODE_8  = 2'd0,
        BIT_MODE_16 = 2'd1,
        BIT_MODE_32 = 2'd2,
        BIT_MODE_64 = 2'd3
    } bit_mode_t;

    typedef enum logic [1:0] {
        DISABLED_SIGN_MODE             = 2'd0,
        ENABLED_SIGNED_SIGNED_MODE     = 2'd1,
        ENABLED_UNSIGNED_UNSIGNED_MODE = 2'd2,
        ENABLED_SIGNED_UNSIGNED_MODE   = 2'd3
    } sign_mode_t;

    typedef enum logic {
        DISABLED_MAXIMUM_MODE = 1'b0,
        ENABLED_MAXIMUM_MODE  = 1'b1
    } maximum_mode_t;

    typedef enum logic {
        DISABLED_MINIMUM_MODE = 1'b0,
        ENABLED_MINIMUM_MODE  = 1'b1
    } minimum_mode_t;

    typedef struct packed {
        bit_mode_t     bit_mode;
        sign_mode_t    sign_mode;
        maximum_mode_t maximum_mode;
        minimum_mode_t minimum_mode;
    } execution_vector_t;

endpackage

module vector_reduction_minmax_unit
    import vector_reduction_minmax_pkg::*;
#(
    parameter int ELEMENT_COUNT_WIDTH = 12
) (
    input  logic                           clock,
    input  logic                           reset,
    input  execution_vector_t              execution_vector,
    input  logic                           start,
    input  logic [ELEMENT_COUNT_WIDTH-1:0] element_count,
    input  logic [63:0]                    scalar_seed,
    output logic                           busy,
    input  logic                           beat_valid,
    output logic                           beat_ready,
    input  logic [63:0]                    vs2_beat,
`ifdef VECTOR_REDUCTION_MASK_EN
    input  logic [7:0]                     beat_mask,
`endif
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic [63:0]                    vd
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ACCUMULATE = 2'd1,
        ST_DONE       = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Element helpers
    // ------------------------------------------------------------------------

    // Mask that keeps only the low SEW bits of a 64-bit word.
    function automatic logic [63:0] sew_mask(input bit_mode_t m);
        case (m)
            BIT_MODE_8:  sew_mask = 64'h0000_0000_0000_00FF;
            BIT_MODE_16: sew_mask = 64'h0000_0000_0000_FFFF;
            BIT_MODE_32: sew_mask = 64'h0000_0000_FFFF_FFFF;
            default:     sew_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Number of SEW lanes carried by one 64-bit beat.
    function automatic logic [3:0] lanes_of(input bit_mode_t m);
        case (m)
            BIT_MODE_8:  lanes_of = 4'd8;
            BIT_MODE_16: lanes_of = 4'd4;
            BIT_MODE_32: lanes_of = 4'd2;
            default:     lanes_of = 4'd1;
        endcase
    endfunction

    // Lane i of a beat, zero-extended into the accumulator format.
    function automatic logic [63:0] lane_value(input logic [63:0] beat,
                                               input bit_mode_t   m,
                                               input int          i);
        case (m)
            BIT_MODE_8:  lane_value = {56'd0, beat[(i % 8) * 8 +: 8]};
            BIT_MODE_16: lane_value = {48'd0, beat[(i % 4) * 16 +: 16]};
            BIT_MODE_32: lane_value = {32'd0, beat[(i % 2) * 32 +: 32]};
            default:     lane_value = beat;
        endcase
    endfunction

    // Widen an SEW value to 65 bits so one signed compare covers both the
    // signed and the unsigned interpretation.
    function automatic logic signed [64:0] to_key(input logic [63:0] v,
                                                  input bit_mode_t   m,
                                                  input logic        is_signed);
        case (m)
            BIT_MODE_8:  to_key = is_signed ? {{57{v[7]}},  v[7:0]}  : {57'd0, v[7:0]};
            BIT_MODE_16: to_key = is_signed ? {{49{v[15]}}, v[15:0]} : {49'd0, v[15:0]};
            BIT_MODE_32: to_key = is_signed ? {{33{v[31]}}, v[31:0]} : {33'd0, v[31:0]};
            default:     to_key = is_signed ? {v[63], v}             : {1'b0, v};
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                         state_q,        state_d;
    logic [63:0]                    acc_q,          acc_d;
    logic [ELEMENT_COUNT_WIDTH-1:0] remaining_q,    remaining_d;
    bit_mode_t                      bit_mode_q,     bit_mode_d;
    logic                           signed_q,       signed_d;
    logic                           max_q,          max_d;
    logic                           min_q,          min_d;
    logic                           busy_q,         busy_d;
    logic                           beat_ready_q,   beat_ready_d;
    logic                           result_valid_q, result_valid_d;
    logic [63:0]                    vd_q,           vd_d;

    logic [7:0]                     w_lane_mask;
    logic [3:0]                     w_lane_count;
    logic [ELEMENT_COUNT_WIDTH-1:0] w_lane_count_ext;
    logic [ELEMENT_COUNT_WIDTH-1:0] w_take;
    logic [63:0]                    w_fold;
    logic                           w_beat_fire;

`ifdef VECTOR_REDUCTION_MASK_EN
    assign w_lane_mask = beat_mask;
`else
    assign w_lane_mask = 8'hFF;
`endif

    assign w_lane_count     = lanes_of(bit_mode_q);
    assign w_lane_count_ext = ELEMENT_COUNT_WIDTH'(w_lane_count);
    assign w_take           = (remaining_q < w_lane_count_ext) ? remaining_q : w_lane_count_ext;
    assign w_beat_fire      = beat_valid && beat_ready_q;

    // Fold every active lane of the current beat into the accumulator,
    // lane 0 first; a lane replaces the running value only on a strict win.
    always_comb begin
        logic signed [64:0] cand_key;
        logic signed [64:0] cur_key;
        logic               lane_active;
        w_fold      = acc_q;
        cand_key    = '0;
        cur_key     = '0;
        lane_active = 1'b0;
        for (int i = 0; i < 8; i++) begin
            lane_active = (4'(i) < w_lane_count)
                       && (ELEMENT_COUNT_WIDTH'(i) < remaining_q)
                       && w_lane_mask[i];
            cand_key = to_key(lane_value(vs2_beat, bit_mode_q, i), bit_mode_q, signed_q);
            cur_key  = to_key(w_fold, bit_mode_q, signed_q);
            if (lane_active) begin
                if (max_q) begin
                    if (cand_key > cur_key) begin
                        w_fold = lane_value(vs2_beat, bit_mode_q, i);
                    end
                end else if (min_q) begin
                    if (cand_key < cur_key) begin
                        w_fold = lane_value(vs2_beat, bit_mode_q, i);
                    end
                end
            end
        end
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        bit_mode_d  = bit_mode_q;
        signed_d    = signed_q;
        max_d       = max_q;
        min_d       = min_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d       = scalar_seed & sew_mask(execution_vector.bit_mode);
                    bit_mode_d  = execution_vector.bit_mode;
                    signed_d    = (execution_vector.sign_mode == ENABLED_SIGNED_SIGNED_MODE);
                    max_d       = (execution_vector.maximum_mode == ENABLED_MAXIMUM_MODE);
                    min_d       = (execution_vector.minimum_mode == ENABLED_MINIMUM_MODE);
                    remaining_d = element_count;
                    state_d     = (element_count == '0) ? ST_DONE : ST_ACCUMULATE;
                end
            end
            ST_ACCUMULATE: begin
                if (w_beat_fire) begin
                    acc_d       = w_fold;
                    remaining_d = remaining_q - w_take;
                    if (remaining_d == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (result_valid_q && result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d         = (state_d != ST_IDLE);
        beat_ready_d   = (state_d == ST_ACCUMULATE);
        result_valid_d = (state_d == ST_DONE);
        vd_d           = (state_d == ST_DONE) ? acc_d : 64'd0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            acc_q          <= 64'd0;
            remaining_q    <= '0;
            bit_mode_q     <= BIT_MODE_8;
            signed_q       <= 1'b0;
            max_q          <= 1'b0;
            min_q          <= 1'b0;
            busy_q         <= 1'b0;
            beat_ready_q   <= 1'b0;
            result_valid_q <= 1'b0;
            vd_q           <= 64'd0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            remaining_q    <= remaining_d;
            bit_mode_q     <= bit_mode_d;
            signed_q       <= signed_d;
            max_q          <= max_d;
            min_q          <= min_d;
            busy_q         <= busy_d;
            beat_ready_q   <= beat_ready_d;
            result_valid_q <= result_valid_d;
            vd_q           <= vd_d;
        end
    end

    assign busy         = busy_q;
    assign beat_ready   = beat_ready_q;
    assign result_valid = result_valid_q;
    assign vd           = vd_q;

endmodule

`default_nettype wire
